uart_mem_loader: RTL and testbench

//   Sits between the UART RX/TX byte engines and the CPU instruction/data memories.
//   In load mode it packs received bytes into 32-bit words and writes them to IM or DM.
//   In dump mode it reads IM or DM and streams each word out as bytes.
//   It drives the im_done/dm_done flags that appear on led[7]/led[6].

---
 rtl/uart_mem_loader.sv | 191 +++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_mem_loader
// Brief    : Bridges UART byte engines and IM/DM: packs RX bytes into words
//            (load) or streams memory words out as TX bytes (dump).
// Revision : 1.0  initial release
// ============================================================================
module uart_mem_loader #(
  parameter int ADDR_W   = 8,
  parameter int IM_WORDS = 256,
  parameter int DM_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_on,
  input  logic              uart_mode,
  input  logic              uart_ram_id,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              im_done,
  output logic              dm_done
);

  localparam logic [ADDR_W:0] c_im_last = (ADDR_W+1)'(IM_WORDS - 1);
  localparam logic [ADDR_W:0] c_dm_last = (ADDR_W+1)'(DM_WORDS - 1);
  localparam logic [ADDR_W:0] c_one     = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_DUMP_RD   = 3'd2,
    S_DUMP_CAP  = 3'd3,
    S_DUMP_SEND = 3'd4,
    S_DUMP_GAP  = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t          r_state, w_nxt_state;
  logic            r_sel, w_nxt_sel;
  logic            r_mode, w_nxt_mode;
  logic [1:0]      r_byte_cnt, w_nxt_byte_cnt;
  logic [ADDR_W:0] r_word_cnt, w_nxt_word_cnt;
  logic [31:0]     r_word, w_nxt_word;
  logic            r_wpend, w_nxt_wpend;
  logic            r_im_done, w_nxt_im_done;
  logic            r_dm_done, w_nxt_dm_done;
  logic [7:0]      r_tx_hold, w_nxt_tx_hold;

  logic [ADDR_W:0] w_last;
  logic [7:0]      w_cur_byte;
  logic            w_session_ok;

  // r_word is the assembly buffer in load mode and the read-back buffer in dump mode
  assign w_last       = r_sel ? c_dm_last : c_im_last;
  assign w_cur_byte   = r_word[{r_byte_cnt, 3'b000} +: 8];
  assign w_session_ok = uart_on && (uart_ram_id == r_sel) && (uart_mode == r_mode);

  assign mem_sel   = r_sel;
  assign mem_addr  = r_word_cnt[ADDR_W-1:0];
  assign mem_we    = r_wpend;
  assign mem_wdata = r_wpend ? r_word : 32'd0;
  assign mem_re    = (r_state == S_DUMP_RD);
  assign tx_start  = (r_state == S_DUMP_SEND) && tx_ready && w_session_ok;
  assign tx_data   = tx_start ? w_cur_byte : r_tx_hold;
  assign im_done   = r_im_done;
  assign dm_done   = r_dm_done;

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_sel      = r_sel;
    w_nxt_mode     = r_mode;
    w_nxt_byte_cnt = r_byte_cnt;
    w_nxt_word_cnt = r_word_cnt;
    w_nxt_word     = r_word;
    w_nxt_wpend    = 1'b0;
    w_nxt_im_done  = r_im_done;
    w_nxt_dm_done  = r_dm_done;
    w_nxt_tx_hold  = r_tx_hold;

    if (!uart_on) begin
      w_nxt_state    = S_IDLE;
      w_nxt_byte_cnt = 2'd0;
      w_nxt_word_cnt = '0;
      w_nxt_word     = 32'd0;
    end else if ((r_state == S_IDLE) || (uart_ram_id != r_sel)) begin
      // session (re)start: a RAM switch behaves exactly like a fresh entry from IDLE
      w_nxt_sel      = uart_ram_id;
      w_nxt_mode     = uart_mode;
      w_nxt_byte_cnt = 2'd0;
      w_nxt_word_cnt = '0;
      w_nxt_word     = 32'd0;
      if (uart_ram_id) w_nxt_dm_done = 1'b0;
      else             w_nxt_im_done = 1'b0;
      w_nxt_state    = uart_mode ? S_DUMP_RD : S_LOAD;
    end else if (uart_mode != r_mode) begin
      w_nxt_state    = S_IDLE;
      w_nxt_byte_cnt = 2'd0;
      w_nxt_word_cnt = '0;
      w_nxt_word     = 32'd0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (r_wpend && (r_word_cnt == w_last)) begin
            if (r_sel) w_nxt_dm_done = 1'b1;
            else       w_nxt_im_done = 1'b1;
            w_nxt_state = S_DONE;
          end else begin
            if (r_wpend) w_nxt_word_cnt = r_word_cnt + c_one;
            if (rx_valid) begin
              w_nxt_word[{r_byte_cnt, 3'b000} +: 8] = rx_data;
              w_nxt_byte_cnt = r_byte_cnt + 2'd1;
              if (r_byte_cnt == 2'd3) w_nxt_wpend = 1'b1;
            end
          end
        end
        S_DUMP_RD: begin
          w_nxt_state = S_DUMP_CAP;
        end
        S_DUMP_CAP: begin
          w_nxt_word     = mem_rdata;
          w_nxt_byte_cnt = 2'd0;
          w_nxt_state    = S_DUMP_SEND;
        end
        S_DUMP_SEND: begin
          if (tx_ready) begin
            w_nxt_tx_hold = w_cur_byte;
            w_nxt_state   = S_DUMP_GAP;
          end
        end
        S_DUMP_GAP: begin
          // TX deasserts ready one cycle after the start strobe, so tx_ready is not trusted here
          if (r_byte_cnt != 2'd3) begin
            w_nxt_byte_cnt = r_byte_cnt + 2'd1;
            w_nxt_state    = S_DUMP_SEND;
          end else if (r_word_cnt != w_last) begin
            w_nxt_word_cnt = r_word_cnt + c_one;
            w_nxt_state    = S_DUMP_RD;
          end else begin
            if (r_sel) w_nxt_dm_done = 1'b1;
            else       w_nxt_im_done = 1'b1;
            w_nxt_state = S_DONE;
          end
        end
        S_DONE: begin
          w_nxt_state = S_DONE;
        end
        default: begin
          w_nxt_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_mode     <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_word_cnt <= '0;
      r_word     <= 32'd0;
      r_wpend    <= 1'b0;
      r_im_done  <= 1'b0;
      r_dm_done  <= 1'b0;
      r_tx_hold  <= 8'd0;
    end else begin
      r_state    <= w_nxt_state;
      r_sel      <= w_nxt_sel;
      r_mode     <= w_nxt_mode;
      r_byte_cnt <= w_nxt_byte_cnt;
      r_word_cnt <= w_nxt_word_cnt;
      r_word     <= w_nxt_word;
      r_wpend    <= w_nxt_wpend;
      r_im_done  <= w_nxt_im_done;
      r_dm_done  <= w_nxt_dm_done;
      r_tx_hold  <= w_nxt_tx_hold;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_loader
// Brief    : Scoreboard bench for uart_mem_loader (IM_WORDS=3, DM_WORDS=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        uart_on, uart_mode, uart_ram_id;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        mem_sel;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic [31:0] mem_rdata = 32'd0;
  logic        im_done, dm_done;

  always #5 clk = ~clk;

  uart_mem_loader #(.ADDR_W(8), .IM_WORDS(3), .DM_WORDS(2)) dut (
    .clk(clk), .reset(reset), .uart_on(uart_on), .uart_mode(uart_mode),
    .uart_ram_id(uart_ram_id), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .im_done(im_done), .dm_done(dm_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_tx  = 0;
  logic [40:0] exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] dm_mem [0:3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // memory read model: data one cycle after mem_re
  always @(posedge clk) if (mem_re) mem_rdata <= dm_mem[mem_addr[1:0]];

  // TX model: busy for a few cycles after each start, ready also gated by a toggling phase
  logic tx_en = 1'b0;
  logic tog   = 1'b0;
  int   busy  = 0;
  always @(posedge clk) begin
    tog <= ~tog;
    if (tx_start) busy <= 3;
    else if (busy > 0) busy <= busy - 1;
  end
  assign tx_ready = tx_en && (busy == 0) && tog;

  // monitor: pops the scoreboard whenever the DUT presents a strobe
  always @(negedge clk) begin
    if (mem_we || mem_re || tx_start)
      chk("strobe_excl", 64'($countones({mem_we, mem_re, tx_start})), 64'd1);
    if (mem_we) begin
      if (exp_wr.size() == 0) chk("unexpected_write", {mem_sel, mem_addr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("mem_write", {mem_sel, mem_addr, mem_wdata}, exp_wr.pop_front());
    end
    if (tx_start) begin
      n_tx++;
      chk("tx_ready_at_start", tx_ready, 1);
      if (exp_tx.size() == 0) chk("unexpected_tx", tx_data, 64'hFFFF);
      else chk("tx_byte", tx_data, exp_tx.pop_front());
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic send_word(input logic [31:0] w, input logic sel, input logic [7:0] addr, input int gap);
    exp_wr.push_back({sel, addr, w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic push_tx(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_tx(input int target, input int max_cyc);
    int k;
    k = 0;
    while (n_tx < target && k < max_cyc) begin tick(); k++; end
    if (n_tx < target) chk("wait_tx_timeout", n_tx, target);
  endtask

  task automatic wait_dm_done(input int max_cyc);
    int k;
    k = 0;
    while (!dm_done && k < max_cyc) begin tick(); k++; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"},  tx_data, 0);
    chk({tag, "_mem_we"},   mem_we, 0);
    chk({tag, "_mem_re"},   mem_re, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_sel"},  mem_sel, 0);
    chk({tag, "_im_done"},  im_done, 0);
    chk({tag, "_dm_done"},  dm_done, 0);
  endtask

  initial begin
    int base;
    reset = 1'b0; uart_on = 1'b0; uart_mode = 1'b0; uart_ram_id = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    dm_mem[0] = 32'hDEADBEEF; dm_mem[1] = 32'h01020304;
    dm_mem[2] = 32'h0; dm_mem[3] = 32'h0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b1;
    tick(2);

    // 1: load IM, three words with idle gaps between bytes
    uart_on = 1'b1; tick();
    send_word(32'h20080024, 1'b0, 8'd0, 1);
    send_word(32'h21090001, 1'b0, 8'd1, 1);
    chk("im_done_before_last", im_done, 0);
    send_word(32'h00000013, 1'b0, 8'd2, 1);
    tick(2);
    chk("im_done_t1", im_done, 1);
    chk("dm_done_t1", dm_done, 0);
    send_byte(8'h55, 1);                       // ignored in DONE
    uart_on = 1'b0; tick(2);

    // 2: partial word discarded by dropping uart_on
    uart_on = 1'b1; tick(2);
    chk("im_done_cleared", im_done, 0);
    send_byte(8'hAA, 1); send_byte(8'hBB, 1);
    uart_on = 1'b0; tick(2);
    uart_on = 1'b1; tick();
    send_word(32'h44332211, 1'b0, 8'd0, 1);
    tick(2);
    uart_on = 1'b0; tick(2);

    // 3 + 5: back-to-back bytes (byte 0 lands on the write cycle), then RAM switch to DM
    uart_on = 1'b1; tick();
    send_word(32'h03020100, 1'b0, 8'd0, 0);
    send_word(32'h07060504, 1'b0, 8'd1, 0);
    send_word(32'h0B0A0908, 1'b0, 8'd2, 0);
    tick(2);
    chk("im_done_t3", im_done, 1);
    uart_ram_id = 1'b1; tick();
    send_word(32'hCAFEBABE, 1'b1, 8'd0, 0);
    send_word(32'h12345678, 1'b1, 8'd1, 0);
    tick(2);
    chk("dm_done_t3", dm_done, 1);
    chk("im_done_kept", im_done, 1);
    uart_on = 1'b0; tick(2);

    // 4: dump DM with a toggling TX ready
    base = n_tx;
    push_tx(32'hDEADBEEF); push_tx(32'h01020304);
    tx_en = 1'b1; uart_mode = 1'b1; uart_on = 1'b1;
    tick(2);
    chk("dm_done_cleared", dm_done, 0);
    wait_dm_done(500);
    chk("dm_done_t4", dm_done, 1);
    chk("tx_count_t4", n_tx - base, 8);
    chk("tx_queue_empty", exp_tx.size(), 0);
    chk("im_done_t4", im_done, 1);
    uart_on = 1'b0; tick(2);

    // 6: async reset in the middle of a dump
    base = n_tx;
    push_tx(32'hDEADBEEF); push_tx(32'h01020304);
    uart_on = 1'b1;
    wait_tx(base + 2, 300);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    exp_tx.delete();
    tick(3);
    uart_on = 1'b0; reset = 1'b1;
    base = n_tx;
    tick(20);
    chk("tx_after_reset", n_tx - base, 0);
    chk("wr_queue_empty", exp_wr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
